k6502_timing: RTL and testbench

//  Upstream of k6502_data: generates ph1/ph2 phase strobes from one clock, sequences T-states,

---
 rtl/k6502_timing_pkg.sv | 19 +
 rtl/k6502_timing_if.sv | 28 ++
 rtl/k6502_timing_int_sync.sv | 36 +++
 rtl/k6502_timing.sv | 124 ++++++++++++
 tb/tb_k6502_timing.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/k6502_timing_pkg.sv
// Shared types and constants for the k6502 timing/sequencing block.
package k6502_timing_pkg;

  typedef enum logic [1:0] {
    INT_NONE = 2'd0,
    INT_RES  = 2'd1,
    INT_NMI  = 2'd2,
    INT_IRQ  = 2'd3
  } int_kind_t;

  typedef enum logic {
    PH_1 = 1'b0,
    PH_2 = 1'b1
  } phase_t;

  localparam logic [2:0] T_FETCH = 3'd1;
  localparam logic [7:0] OP_BRK  = 8'h00;

endpackage

// File: rtl/k6502_timing_if.sv
// Bus between the timing block (slave) and the decode/data side (master).
interface k6502_timing_if;

  logic [7:0]                   pd;
  logic                         rdy;
  logic                         rw;
  logic                         t_end;
  logic                         i_flag;
  logic                         ph1;
  logic                         ph2;
  logic [2:0]                   t_state;
  logic                         sync;
  logic [7:0]                   ir;
  k6502_timing_pkg::int_kind_t  int_kind;
  logic                         pc_inh;
  logic                         t_err;

  modport master (
    output pd, rdy, rw, t_end, i_flag,
    input  ph1, ph2, t_state, sync, ir, int_kind, pc_inh, t_err
  );

  modport slave (
    input  pd, rdy, rw, t_end, i_flag,
    output ph1, ph2, t_state, sync, ir, int_kind, pc_inh, t_err
  );

endinterface

// File: rtl/k6502_timing_int_sync.sv
// Synchronizer chain for an async active-low interrupt pin; emits either the
// synced level or a one-clk falling-edge pulse.
module k6502_timing_int_sync #(
  parameter int SYNC_LEN  = 2,
  parameter bit FALL_EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_n_i,
  output logic out_o
);

  logic [SYNC_LEN-1:0] sync_q;
  logic [SYNC_LEN-1:0] sync_d;

  always_comb sync_d = {sync_q[SYNC_LEN-2:0], pin_n_i};

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= sync_d;
  end

  if (FALL_EDGE) begin : g_fall
    logic prev_q;
    always_ff @(posedge clk) begin
      if (rst) prev_q <= 1'b1;
      else     prev_q <= sync_q[SYNC_LEN-1];
    end
    assign out_o = prev_q & ~sync_q[SYNC_LEN-1];
  end else begin : g_level
    assign out_o = sync_q[SYNC_LEN-1];
  end

endmodule

// File: rtl/k6502_timing.sv
// Phase generator, T-state sequencer, IR latch and RES/NMI/IRQ arbitration
// feeding the random-control decode of k6502_data.
module k6502_timing
  import k6502_timing_pkg::*;
#(
  parameter int MAX_T    = 7,
  parameter int SYNC_LEN = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           nmi_n_i,
  input  logic           irq_n_i,
  k6502_timing_if.slave  bus
);

  localparam logic [2:0] T_LAST = 3'(MAX_T);

  phase_t     phase_q, phase_d;
  logic [2:0] t_state_q, t_state_d;
  logic [7:0] ir_q, ir_d;
  int_kind_t  int_kind_q, int_kind_d;
  logic       pc_inh_q, pc_inh_d;
  logic       t_err_q, t_err_d;
  logic       nmi_lat_q, nmi_lat_d;
  logic       commit, fetch, irq_lvl_n, nmi_fall, irq_pend;
  int_kind_t  sel_kind;

  k6502_timing_int_sync #(.SYNC_LEN(SYNC_LEN), .FALL_EDGE(1'b1)) u_nmi_sync (
    .clk(clk), .rst(rst), .pin_n_i(nmi_n_i), .out_o(nmi_fall)
  );

  k6502_timing_int_sync #(.SYNC_LEN(SYNC_LEN), .FALL_EDGE(1'b0)) u_irq_sync (
    .clk(clk), .rst(rst), .pin_n_i(irq_n_i), .out_o(irq_lvl_n)
  );

  // Phase FSM: state register / next state / outputs.
  always_ff @(posedge clk) begin
    if (rst) phase_q <= PH_1;
    else     phase_q <= phase_d;
  end

  always_comb phase_d = (phase_q == PH_1) ? PH_2 : PH_1;

  always_comb begin
    bus.ph1 = (phase_q == PH_1);
    bus.ph2 = (phase_q == PH_2);
    // A stalled read cycle keeps the phases running but never commits.
    commit  = (phase_q == PH_2) && !(!bus.rdy && bus.rw);
  end

  assign fetch    = (t_state_q == T_FETCH);
  assign irq_pend = !irq_lvl_n && !bus.i_flag;
  assign sel_kind = nmi_lat_q ? INT_NMI : (irq_pend ? INT_IRQ : INT_NONE);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and a latch can never be inferred.
  always_comb begin
    t_state_d  = t_state_q;
    ir_d       = ir_q;
    int_kind_d = int_kind_q;
    pc_inh_d   = pc_inh_q;
    t_err_d    = t_err_q;
    nmi_lat_d  = nmi_fall | nmi_lat_q;

    if (commit) begin
      if (bus.t_end) begin
        t_state_d = T_FETCH;
      end else if (t_state_q == T_LAST) begin
        t_state_d = T_FETCH;
        t_err_d   = 1'b1;
      end else begin
        t_state_d = t_state_q + 3'd1;
      end

      // pc_inh set on a fetch marks it as a forced BRK for the selected interrupt.
      if (fetch) begin
        if (pc_inh_q) begin
          ir_d = OP_BRK;
        end else begin
          ir_d       = bus.pd;
          int_kind_d = INT_NONE;
          pc_inh_d   = 1'b0;
        end
      end

      if (bus.t_end) begin
        if (sel_kind != INT_NONE) begin
          int_kind_d = sel_kind;
          pc_inh_d   = 1'b1;
        end else begin
          pc_inh_d   = 1'b0;
        end
        // A new edge arriving on the clearing clk keeps the latch set.
        if (sel_kind == INT_NMI) nmi_lat_d = nmi_fall;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      t_state_q  <= T_FETCH;
      ir_q       <= OP_BRK;
      int_kind_q <= INT_RES;
      pc_inh_q   <= 1'b1;
      t_err_q    <= 1'b0;
      nmi_lat_q  <= 1'b0;
    end else begin
      t_state_q  <= t_state_d;
      ir_q       <= ir_d;
      int_kind_q <= int_kind_d;
      pc_inh_q   <= pc_inh_d;
      t_err_q    <= t_err_d;
      nmi_lat_q  <= nmi_lat_d;
    end
  end

  assign bus.t_state  = t_state_q;
  assign bus.sync     = fetch;
  assign bus.ir       = ir_q;
  assign bus.int_kind = int_kind_q;
  assign bus.pc_inh   = pc_inh_q;
  assign bus.t_err    = t_err_q;

endmodule

// File: tb/tb_k6502_timing.sv
// Directed bench for k6502_timing: per-machine-cycle vector table plus
// hand-written NMI edge/clear and mid-instruction reset sequences.
module tb_k6502_timing;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic nmi_n = 1'b1;
  logic irq_n = 1'b1;

  int n_checks = 0;
  int n_errors = 0;

  k6502_timing_if bus_if ();

  k6502_timing #(.MAX_T(7), .SYNC_LEN(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .nmi_n_i (nmi_n),
    .irq_n_i (irq_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  // One record per machine cycle: pins driven during it, state expected after its commit.
  // kind: 0=NONE 1=RES 2=NMI 3=IRQ; pc=2 means pc_inh not compared.
  typedef struct {
    int pd, rdy, rw, te, ifl, irq, nmi;
    int t, ir, kind, pc, terr;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int pd, rdy, rw, te, ifl, irq, nmi,
                     input int t, ir, kind, pc, terr);
    vec_t v;
    v.pd = pd; v.rdy = rdy; v.rw = rw; v.te = te; v.ifl = ifl; v.irq = irq; v.nmi = nmi;
    v.t = t; v.ir = ir; v.kind = kind; v.pc = pc; v.terr = terr;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int pd, rdy, rw, te, ifl, irq, nmi);
    bus_if.pd     = 8'(pd);
    bus_if.rdy    = rdy[0];
    bus_if.rw     = rw[0];
    bus_if.t_end  = te[0];
    bus_if.i_flag = ifl[0];
    irq_n         = irq[0];
    nmi_n         = nmi[0];
  endtask

  task automatic check_state(input string tag, input int t, ir, kind, pc, terr);
    logic [31:0] e_sync;
    e_sync = (t == 1) ? 32'd1 : 32'd0;
    check({tag, " ph1"},      32'(bus_if.ph1), 32'd1);
    check({tag, " ph2"},      32'(bus_if.ph2), 32'd0);
    check({tag, " t_state"},  32'(bus_if.t_state), t);
    check({tag, " sync"},     32'(bus_if.sync), e_sync);
    check({tag, " ir"},       32'(bus_if.ir), ir);
    check({tag, " int_kind"}, 32'(bus_if.int_kind), kind);
    if (pc != 2) check({tag, " pc_inh"}, 32'(bus_if.pc_inh), pc);
    check({tag, " t_err"},    32'(bus_if.t_err), terr);
  endtask

  // Starts at a ph1 negedge, ends at the ph1 negedge after the commit edge.
  task automatic mcycle(input string tag);
    @(negedge clk);
    check({tag, " mid ph1"}, 32'(bus_if.ph1), 32'd0);
    check({tag, " mid ph2"}, 32'(bus_if.ph2), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    //   pd    rdy rw te if irq nmi   t  ir    k  pc terr
    add('hA9, 1, 1, 0, 1, 1, 1,   2, 'h00, 1, 1, 0);  // RES forced fetch
    add('hA9, 1, 1, 1, 1, 1, 1,   1, 'h00, 1, 2, 0);
    add('hA9, 1, 1, 0, 1, 1, 1,   2, 'hA9, 0, 0, 0);  // normal fetch
    add('hA9, 1, 1, 1, 1, 1, 1,   1, 'hA9, 0, 0, 0);
    add('hEA, 1, 1, 0, 1, 1, 1,   2, 'hEA, 0, 0, 0);
    add('hEA, 0, 1, 0, 1, 1, 1,   2, 'hEA, 0, 0, 0);  // read stall
    add('hEA, 0, 1, 0, 1, 1, 1,   2, 'hEA, 0, 0, 0);
    add('hEA, 1, 1, 0, 1, 1, 1,   3, 'hEA, 0, 0, 0);
    add('hEA, 1, 1, 1, 1, 1, 1,   1, 'hEA, 0, 0, 0);
    add('hEA, 1, 1, 0, 1, 1, 1,   2, 'hEA, 0, 0, 0);
    add('hEA, 0, 0, 0, 1, 1, 1,   3, 'hEA, 0, 0, 0);  // rdy ignored on writes
    add('hEA, 0, 0, 0, 1, 1, 1,   4, 'hEA, 0, 0, 0);
    add('hEA, 0, 0, 1, 1, 1, 1,   1, 'hEA, 0, 0, 0);
    add('h18, 0, 1, 0, 1, 1, 1,   1, 'hEA, 0, 0, 0);  // stalled fetch repeats
    add('h18, 1, 1, 0, 1, 1, 1,   2, 'h18, 0, 0, 0);
    add('h18, 1, 1, 0, 0, 0, 1,   3, 'h18, 0, 0, 0);  // IRQ asserted
    add('h18, 1, 1, 0, 0, 0, 1,   4, 'h18, 0, 0, 0);
    add('h18, 1, 1, 1, 0, 0, 1,   1, 'h18, 3, 1, 0);  // IRQ taken at T4 end
    add('h58, 1, 1, 0, 1, 1, 1,   2, 'h00, 3, 1, 0);
    add('h58, 1, 1, 1, 1, 1, 1,   1, 'h00, 3, 2, 0);
    add('h58, 1, 1, 0, 1, 1, 1,   2, 'h58, 0, 0, 0);
    add('h58, 1, 1, 0, 1, 0, 1,   3, 'h58, 0, 0, 0);  // masked IRQ
    add('h58, 1, 1, 1, 1, 0, 1,   1, 'h58, 0, 0, 0);
    add('hEA, 1, 1, 0, 1, 0, 1,   2, 'hEA, 0, 0, 0);
    add('hEA, 1, 1, 0, 0, 0, 1,   3, 'hEA, 0, 0, 0);
    add('hEA, 1, 1, 0, 0, 1, 1,   4, 'hEA, 0, 0, 0);  // IRQ withdrawn
    add('hEA, 1, 1, 1, 0, 1, 1,   1, 'hEA, 0, 0, 0);
    add('hEA, 1, 1, 0, 0, 0, 0,   2, 'hEA, 0, 0, 0);  // NMI + IRQ together
    add('hEA, 1, 1, 1, 0, 0, 0,   1, 'hEA, 2, 1, 0);
    add('hEA, 1, 1, 0, 0, 0, 0,   2, 'h00, 2, 1, 0);
    add('hEA, 1, 1, 1, 0, 0, 0,   1, 'h00, 3, 1, 0);  // IRQ next, NMI latch clear
    add('hEA, 1, 1, 0, 1, 1, 0,   2, 'h00, 3, 1, 0);
    add('hEA, 1, 1, 1, 1, 1, 0,   1, 'h00, 3, 2, 0);
    add('hEA, 1, 1, 0, 1, 1, 1,   2, 'hEA, 0, 0, 0);
    add('hEA, 1, 1, 0, 1, 1, 1,   3, 'hEA, 0, 0, 0);  // no t_end: overrun
    add('hEA, 1, 1, 0, 1, 1, 1,   4, 'hEA, 0, 0, 0);
    add('hEA, 1, 1, 0, 1, 1, 1,   5, 'hEA, 0, 0, 0);
    add('hEA, 1, 1, 0, 1, 1, 1,   6, 'hEA, 0, 0, 0);
    add('hEA, 1, 1, 0, 1, 1, 1,   7, 'hEA, 0, 0, 0);
    add('hEA, 1, 1, 0, 1, 1, 1,   1, 'hEA, 0, 0, 1);
    add('hA9, 1, 1, 0, 1, 1, 1,   2, 'hA9, 0, 0, 1);
    add('hA9, 1, 1, 1, 1, 1, 1,   1, 'hA9, 0, 0, 1);

    drive('hA9, 1, 1, 0, 1, 1, 1);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_state("reset", 1, 'h00, 1, 1, 0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].pd, vecs[i].rdy, vecs[i].rw, vecs[i].te,
            vecs[i].ifl, vecs[i].irq, vecs[i].nmi);
      mcycle($sformatf("v%0d", i));
      check_state($sformatf("v%0d", i), vecs[i].t, vecs[i].ir, vecs[i].kind,
                  vecs[i].pc, vecs[i].terr);
    end

    // Second NMI edge lands on the clk that clears the latch: NMI must be taken twice.
    drive('hEA, 1, 1, 0, 1, 1, 0);
    @(negedge clk); nmi_n = 1'b1;
    @(negedge clk);
    check_state("nmi_x", 2, 'hEA, 0, 0, 1);
    drive('hEA, 1, 1, 0, 1, 1, 1);
    @(negedge clk); nmi_n = 1'b0;
    @(negedge clk);
    check_state("nmi_y", 3, 'hEA, 0, 0, 1);
    drive('hEA, 1, 1, 1, 1, 1, 0);
    mcycle("nmi_z");
    check_state("nmi_z", 1, 'hEA, 2, 1, 1);
    drive('hEA, 1, 1, 0, 1, 1, 0);
    mcycle("nmi_w");
    check_state("nmi_w", 2, 'h00, 2, 1, 1);
    drive('hEA, 1, 1, 1, 1, 1, 0);
    mcycle("nmi_v");
    check_state("nmi_v", 1, 'h00, 2, 1, 1);
    drive('hEA, 1, 1, 0, 1, 1, 0);
    mcycle("nmi_u");
    check_state("nmi_u", 2, 'h00, 2, 1, 1);
    drive('hEA, 1, 1, 1, 1, 1, 0);
    mcycle("nmi_s");
    check_state("nmi_s", 1, 'h00, 2, 2, 1);
    drive('hEA, 1, 1, 0, 1, 1, 0);
    mcycle("nmi_r");
    check_state("nmi_r", 2, 'hEA, 0, 0, 1);

    // Reset during ph2 of T2 abandons the instruction and clears t_err.
    drive('hEA, 1, 1, 0, 1, 1, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_state("midrst", 1, 'h00, 1, 1, 0);
    drive('hA9, 1, 1, 0, 1, 1, 1);
    mcycle("midrst_f");
    check_state("midrst_f", 2, 'h00, 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
